// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op codes, state encoding and constants for the RV32M unit
package mdu_pkg;
  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } mdu_state_e;

  localparam logic [31:0] XLEN_MIN = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
endpackage

// File: rtl/mdu_iterative_if.sv
// rtl/mdu_iterative_if.sv - request/writeback bundle between core and multiply/divide unit
interface mdu_iterative_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] data;
  logic [4:0]      rd;
  logic            enable;

  modport master (
    output start, flush, funct3, op_a, op_b, rd_in,
    input  busy, done, data, rd, enable
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b, rd_in,
    output busy, done, data, rd, enable
  );
endinterface

// File: rtl/mdu_signfix.sv
// rtl/mdu_signfix.sv - conditional two's-complement negate (magnitude or sign restore)
module mdu_signfix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);
  assign res = neg ? (~val + W'(1)) : val;
endmodule

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative RV32M mul/div unit; MDU_EARLY_OUT_EN selects zero/overflow fast paths
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic             clk,
  input logic             rst,
  mdu_iterative_if.slave  bus
);
  mdu_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       f3_q;
  logic [4:0]       rd_cap_q;
  logic [XLEN-1:0]  a_q, b_q, hi_q, lo_q;
  logic             qneg_q, rneg_q;
  logic             done_q;
  logic [XLEN-1:0]  data_q;
  logic [4:0]       rd_q;

  logic            is_div, a_signed, b_signed, sa, sb, b_zero, early, accept;
  logic [XLEN-1:0] mag_a, mag_b;

  assign is_div   = bus.funct3[2];
  assign a_signed = (bus.funct3 == MDU_MULH) || (bus.funct3 == MDU_MULHSU) ||
                    (bus.funct3 == MDU_DIV)  || (bus.funct3 == MDU_REM);
  assign b_signed = (bus.funct3 == MDU_MULH) || (bus.funct3 == MDU_DIV) ||
                    (bus.funct3 == MDU_REM);
  assign sa       = a_signed & bus.op_a[XLEN-1];
  assign sb       = b_signed & bus.op_b[XLEN-1];
  assign b_zero   = (bus.op_b == '0);
  assign accept   = (state_q == ST_IDLE) && bus.start && !bus.flush;

  mdu_signfix #(.W(XLEN)) u_mag_a (.val(bus.op_a), .neg(sa), .res(mag_a));
  mdu_signfix #(.W(XLEN)) u_mag_b (.val(bus.op_b), .neg(sb), .res(mag_b));

`ifdef MDU_EARLY_OUT_EN
  logic ovf, a_zero;
  assign a_zero = (bus.op_a == '0);
  assign ovf    = is_div && !bus.funct3[0] && (bus.op_a == XLEN_MIN) && (bus.op_b == ALL_ONES);
  assign early  = is_div ? (b_zero || ovf) : (a_zero || b_zero);
`else
  assign early  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.start) state_d = early ? ST_FIN : ST_CALC;
        ST_CALC: if (cnt_q == CNT_W'(XLEN-1)) state_d = ST_FIN;
        ST_FIN:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide
  logic [XLEN:0]   mul_sum, rem_sh;
  logic            rem_ge;
  logic [XLEN-1:0] rem_sub;

  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
  assign rem_sh  = {hi_q, lo_q[XLEN-1]};
  assign rem_ge  = rem_sh >= {1'b0, b_q};
  assign rem_sub = rem_sh[XLEN-1:0] - b_q;

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result;

  mdu_signfix #(.W(2*XLEN)) u_fix_p (.val({hi_q, lo_q}), .neg(qneg_q), .res(prod_fix));
  mdu_signfix #(.W(XLEN))   u_fix_q (.val(lo_q), .neg(qneg_q), .res(quo_fix));
  mdu_signfix #(.W(XLEN))   u_fix_r (.val(hi_q), .neg(rneg_q), .res(rem_fix));

  always_comb begin
    result = quo_fix;
    if (!f3_q[2]) result = (f3_q == MDU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else if (f3_q[1]) result = rem_fix;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_cap_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
      data_q   <= '0;
      rd_q     <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          f3_q     <= bus.funct3;
          rd_cap_q <= bus.rd_in;
          a_q      <= mag_a;
          b_q      <= mag_b;
          cnt_q    <= '0;
          hi_q     <= '0;
          lo_q     <= is_div ? mag_a : mag_b;
          // A zero divisor keeps the all-ones quotient positive
          qneg_q   <= (sa ^ sb) & !(is_div && b_zero);
          rneg_q   <= sa;
`ifdef MDU_EARLY_OUT_EN
          if (early) begin
            if (is_div && b_zero) begin
              lo_q <= ALL_ONES;
              hi_q <= mag_a;
            end else if (is_div) begin
              lo_q <= XLEN_MIN;
            end else begin
              lo_q <= '0;
            end
          end
`endif
        end
        ST_CALC: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (f3_q[2]) begin
            hi_q <= rem_ge ? rem_sub : rem_sh[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], rem_ge};
          end else begin
            hi_q <= mul_sum[XLEN:1];
            lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
          end
        end
        ST_FIN: if (!bus.flush) begin
          data_q <= result;
          rd_q   <= rd_cap_q;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.done   = done_q;
  assign bus.data   = data_q;
  assign bus.rd     = rd_q;
  assign bus.enable = done_q && (rd_q != 5'd0);
endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - randomized self-checking bench for mdu_iterative against an arithmetic model
module tb_mdu_iterative;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mdu_iterative_if #(.XLEN(32)) bus ();
  mdu_iterative #(.XLEN(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    if (f[2]) begin
      if (b == 0) return 2;
      if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    end else if (a == 0 || b == 0) begin
      return 2;
    end
`endif
    return 34;
  endfunction

  // Issue one op, stir start/operands while busy, and check the writeback it produces
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r, input string tag);
    int edges;
    logic [31:0] exp;
    exp = ref_mdu(f, a, b);
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b; bus.rd_in = r;
    @(posedge clk); #1;
    edges = 1;
    check({tag, " busy"}, 64'(bus.busy), 64'd1);
    while (!bus.done && edges < 60) begin
      if (edges < 5) begin
        bus.start  = 1'($urandom_range(0, 1));
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
        bus.funct3 = 3'($urandom);
        bus.rd_in  = 5'($urandom);
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
    end
    bus.start = 1'b0;
    check({tag, " latency"}, 64'(edges), 64'(exp_latency(f, a, b)));
    check({tag, " data"}, 64'(bus.data), 64'(exp));
    check({tag, " rd"}, 64'(bus.rd), 64'(r));
    check({tag, " enable"}, 64'(bus.enable), 64'(r != 5'd0));
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
  endtask

  task automatic abort_after(input int k, input bit use_flush, input string tag);
    int pulses;
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = MDU_MUL; bus.op_a = 32'd5; bus.op_b = 32'd6; bus.rd_in = 5'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (k - 1) begin @(posedge clk); #1; end
    if (use_flush) bus.flush = 1'b1; else rst = 1'b0;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    rst = 1'b1;
    check({tag, " busy"}, 64'(bus.busy), 64'd0);
    count_done(40, pulses);
    check({tag, " no done"}, 64'(pulses), 64'd0);
  endtask

  logic [31:0] last_data;
  int          pulses;
  logic [31:0] ra, rb;

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b0;
    bus.start = 1'b1; bus.flush = 1'b0; bus.funct3 = 3'd0;
    bus.op_a = 32'd3; bus.op_b = 32'd4; bus.rd_in = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset enable", 64'(bus.enable), 64'd0);
    check("reset data", 64'(bus.data), 64'd0);
    check("reset rd", 64'(bus.rd), 64'd0);
    bus.start = 1'b0;
    rst = 1'b1;

    run_op(MDU_MUL,    32'd7,          32'hFFFF_FFFD, 5'd5,  "mul");
    run_op(MDU_MULH,   32'd7,          32'hFFFF_FFFD, 5'd5,  "mulh");
    run_op(MDU_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd6,  "mulhu");
    run_op(MDU_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd7,  "mulhsu");
    run_op(MDU_DIV,    32'hFFFF_FFF9,  32'd2,         5'd8,  "div");
    run_op(MDU_REM,    32'hFFFF_FFF9,  32'd2,         5'd8,  "rem");
    run_op(MDU_DIVU,   32'h8000_0000,  32'd2,         5'd10, "divu");
    run_op(MDU_DIV,    32'h12,         32'd0,         5'd11, "div0");
    run_op(MDU_REM,    32'h12,         32'd0,         5'd11, "rem0");
    run_op(MDU_DIVU,   32'h12,         32'd0,         5'd11, "divu0");
    run_op(MDU_REMU,   32'h12,         32'd0,         5'd11, "remu0");
    run_op(MDU_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, "div ovf");
    run_op(MDU_REM,    32'h8000_0000,  32'hFFFF_FFFF, 5'd12, "rem ovf");
    run_op(MDU_MUL,    32'd3,          32'd4,         5'd0,  "mul rd0");
    run_op(MDU_MUL,    32'd0,          32'h1234_5678, 5'd13, "mul zero");

    last_data = bus.data;
    count_done(4, pulses);
    check("single done", 64'(pulses), 64'd0);
    check("data hold", 64'(bus.data), 64'(last_data));

    abort_after(11, 1'b1, "flush calc");
    abort_after(33, 1'b1, "flush fin");
    abort_after(5,  1'b0, "reset mid");
    check("reset mid data", 64'(bus.data), 64'd0);

    for (int i = 0; i < 80; i++) begin
      ra = pick_operand();
      rb = pick_operand();
      run_op(3'($urandom_range(0, 7)), ra, rb, 5'($urandom_range(0, 31)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Iterative RV32M multiply/divide unit, downstream of `register_file`.
- Consumes `op_a`/`op_b` read through `rs1`/`rs2`.
- Returns its result to the register-file write port as `data`/`rd`/`enable`.
- Stalls the core via `busy` while an operation runs (up to 34 cycles).

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-low
- start  input  1  request; sampled only when busy=0
- flush  input  1  abort in-flight operation; no writeback
- funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  XLEN  rs1 value (dividend/multiplicand)
- op_b  input  XLEN  rs2 value (divisor/multiplier)
- rd_in  input  5  destination register captured at start
- busy  output  1  operation accepted and not yet retired
- done  output  1  one-cycle result-valid pulse
- data  output  XLEN  result to register file
- rd  output  5  destination to register file
- enable  output  1  register-file write enable (= done and rd != 0)

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - Reset is synchronous, active-low, on rst: state is sampled only at the posedge clk where rst=0.
- Reset values:
  - busy=0, done=0, enable=0, data=0, rd=0.
  - State IDLE; counter, accumulators and captured operands all 0.
- States:
  - IDLE: busy=0. On start=1 and flush=0, capture funct3, rd_in, op_a, op_b. Take magnitudes of the signed operands: MULH takes both; MULHSU takes only op_a; DIV/REM take both. Record the result sign. Go to CALC with count=0.
  - CALC: busy=1. Runs one iteration per cycle for 32 cycles (count 0..31). The transition to FIN happens on the edge where count=31.
    - Multiply: shift-add on magnitudes into a 64-bit accumulator.
    - Divide: restoring shift-subtract producing a 32-bit quotient and remainder.
  - FIN: busy=1. Apply sign correction (two's-complement negate if the sign flag is set). Select the output:
    - MUL: low 32 bits of the product.
    - MULH/MULHSU/MULHU: high 32 bits.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder; its sign follows the dividend.
    - Register data and rd, pulse done for exactly one cycle, return to IDLE.
- Latency: done is high in the cycle following the 34th rising edge after the edge that sampled start.
- Back-to-back: start may be asserted in the same cycle done=1. The FIN→IDLE edge does not accept; acceptance happens on the next edge.
- data and rd hold their last value after done falls.
- Special cases (results required regardless of path):
  - Divide by zero: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU = op_a.
  - Signed overflow (DIV with op_a=0x80000000, op_b=0xFFFFFFFF): quotient 0x80000000, remainder 0.
  - No exceptions are raised.
- start while busy=1 is ignored; operands are held internally, so input changes have no effect.
- flush=1 in any state: next state IDLE, done=0 and enable=0 for that cycle. flush wins over simultaneous start and over a FIN completion.
- rst=0 mid-operation: full reset on that edge, no writeback.
- enable=0 when rd=0 even though done=1.

Optional Feature:
- MDU_EARLY_OUT_EN defined: divide-by-zero, signed overflow, and multiply with either operand 0 bypass CALC. IDLE goes directly to FIN with the preset result, so done follows 2 edges after start.
- Undefined: every operation takes the full 34-cycle path.
- Results are bit-identical in both builds; only latency differs.

Decomposition:
- Shared package `mdu_pkg` holds:
  - funct3 op localparams (MDU_MUL..MDU_REMU);
  - state encoding (ST_IDLE, ST_CALC, ST_FIN);
  - constants XLEN_MIN = 32'h80000000 and ALL_ONES.
- One sub-module, `mdu_signfix`: combinational magnitude/negate helper. It is instantiated for operand preparation and for result correction.

Test Plan:
- Reset: hold rst=0 for 2 cycles with start=1 → busy=0, done=0, enable=0, data=0.
- MUL: op_a=7, op_b=0xFFFFFFFD (-3), rd_in=5 → after 34 edges, done=1, data=0xFFFFFFEB, rd=5, enable=1. MULH with the same operands → 0xFFFFFFFF. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV/REM: op_a=-7, op_b=2 → DIV 0xFFFFFFFD, REM 0xFFFFFFFF. DIVU 0x80000000/2 → 0x40000000.
- Corner cases:
  - DIV x/0 with op_a=0x12 → 0xFFFFFFFF; REM 0x12.
  - DIV 0x80000000/-1 → 0x80000000; REM 0.
  - Latency is 34 edges without MDU_EARLY_OUT_EN and 2 edges with it.
- Flush and start while busy:
  - start, then flush at CALC count=10 → busy=0 next cycle, no done pulse.
  - A second start while busy is ignored: only one done, carrying the first operation's result.
- rd_in=0, MUL 3×4 → done=1, data=12, enable=0.
